// File: rtl/vga_fetch_pkg.sv
// vga_fetch_pkg: shared constants and FSM state encoding for the VGA fetch block.
// Holds memory/address widths, frame geometry, bank base and ZBT read latency.
package vga_fetch_pkg;
    localparam int LOG_MEM      = 36;
    localparam int LOG_ADDR     = 19;
    localparam int IDX_W        = 18;
    localparam int FRAME_WORDS  = 153600;
    localparam int BANK_OFFSET  = 262144;
    localparam int ZBT_READ_LAT = 2;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
endpackage

// File: rtl/vga_fetch_addr_gen.sv
// fetch_addr_gen: raster read pointer and display bank register.
// Ports: clock/reset; frame_flag+display_bank restart the frame on a new bank;
// advance steps the pointer (wrapping at frame end); word_index and addr out.
module fetch_addr_gen #(
    parameter int ADDR_W      = vga_fetch_pkg::LOG_ADDR,
    parameter int FRAME_WORDS = vga_fetch_pkg::FRAME_WORDS,
    parameter int BANK_OFFSET = vga_fetch_pkg::BANK_OFFSET
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            frame_flag,
    input  logic                            display_bank,
    input  logic                            advance,
    output logic [vga_fetch_pkg::IDX_W-1:0] word_index,
    output logic [ADDR_W-1:0]               addr
);
    import vga_fetch_pkg::*;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bank_q, bank_d;
    // A frame restart beats a same-cycle advance.
    always_comb begin
        bank_d = frame_flag ? display_bank : bank_q;
        idx_d  = frame_flag ? '0 :
                 advance    ? ((idx_q == IDX_W'(FRAME_WORDS - 1)) ? '0 : idx_q + IDX_W'(1)) :
                              idx_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            bank_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            bank_q <= bank_d;
        end
    end
    assign word_index = idx_q;
    assign addr       = (bank_q ? ADDR_W'(BANK_OFFSET) : '0) + ADDR_W'(idx_q);
endmodule

// File: rtl/vga_fetch.sv
// vga_fetch: serves each vga_flag request with one ZBT word read via the arbiter.
// Ports: frame_flag/display_bank (frame restart), vga_flag/done_vga/vga_pixel
// (4-phase handshake to the VGA stage), mem_req/mem_addr/mem_grant/mem_rdata
// (arbiter read port), word_index and sticky overrun (debug).
module vga_fetch #(
    parameter int ADDR_W      = vga_fetch_pkg::LOG_ADDR,
    parameter int DATA_W      = vga_fetch_pkg::LOG_MEM,
    parameter int FRAME_WORDS = vga_fetch_pkg::FRAME_WORDS,
    parameter int BANK_OFFSET = vga_fetch_pkg::BANK_OFFSET,
    parameter int READ_LAT    = vga_fetch_pkg::ZBT_READ_LAT
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            frame_flag,
    input  logic                            display_bank,
    input  logic                            vga_flag,
    output logic                            done_vga,
    output logic [DATA_W-1:0]               vga_pixel,
    output logic                            mem_req,
    output logic [ADDR_W-1:0]               mem_addr,
    input  logic                            mem_grant,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic [vga_fetch_pkg::IDX_W-1:0] word_index,
    output logic                            overrun
);
    import vga_fetch_pkg::*;
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    state_t            state_q, state_d;
    logic              done_q, done_d, req_q, req_d, ovr_q, ovr_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              advance;
    assign advance = (state_q == REQ) && mem_grant;
    fetch_addr_gen #(
        .ADDR_W(ADDR_W),
        .FRAME_WORDS(FRAME_WORDS),
        .BANK_OFFSET(BANK_OFFSET)
    ) u_addr (
        .clock(clock),
        .reset(reset),
        .frame_flag(frame_flag),
        .display_bank(display_bank),
        .advance(advance),
        .word_index(word_index),
        .addr(next_addr)
    );
    // A request dropped early still finishes: DONE sees vga_flag low and
    // releases done_vga after a single cycle.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pix_d   = pix_q;
        lat_d   = lat_q;
        ovr_d   = ovr_q | (frame_flag & ((state_q == REQ) | (state_q == WAIT)));
        case (state_q)
            IDLE: if (vga_flag && !done_q) begin
                state_d = REQ;
                req_d   = 1'b1;
                addr_d  = next_addr;
            end
            REQ: if (mem_grant) begin
                state_d = WAIT;
                req_d   = 1'b0;
                lat_d   = LAT_W'(READ_LAT - 1);
            end
            WAIT: if (lat_q == '0) begin
                state_d = DONE;
                pix_d   = mem_rdata;
                done_d  = 1'b1;
            end else begin
                lat_d = lat_q - LAT_W'(1);
            end
            default: if (!vga_flag) begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            pix_q   <= '0;
            lat_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
            lat_q   <= lat_d;
            ovr_q   <= ovr_d;
        end
    end
    assign done_vga  = done_q;
    assign vga_pixel = pix_q;
    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_vga_fetch.sv
// tb_vga_fetch: self-checking bench for vga_fetch with a frame-pointer model.
module tb_vga_fetch;
    localparam int FRAME = 1024;
    localparam int BOFF  = 262144;
    logic        clock, reset, frame_flag, display_bank, vga_flag, mem_grant;
    logic        done_vga, mem_req, overrun;
    logic [35:0] vga_pixel, mem_rdata;
    logic [18:0] mem_addr;
    logic [17:0] word_index;
    int          n_chk, n_fail;
    int          m_idx;
    bit          m_bank;
    bit          fixed_en;
    logic [35:0] fixed_data;
    logic [18:0] p1;

    vga_fetch #(.FRAME_WORDS(FRAME), .BANK_OFFSET(BOFF)) dut (
        .clock(clock), .reset(reset), .frame_flag(frame_flag), .display_bank(display_bank),
        .vga_flag(vga_flag), .done_vga(done_vga), .vga_pixel(vga_pixel), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_grant(mem_grant), .mem_rdata(mem_rdata),
        .word_index(word_index), .overrun(overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [35:0] mem_fn(input logic [18:0] a);
        return {a[16:0], a} ^ 36'h5A5A5A5A5;
    endfunction

    // Memory: data for an address granted at edge k is on mem_rdata for edge k+2.
    initial begin
        bit          g;
        logic [18:0] a;
        p1 = '0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            g = mem_req && mem_grant;
            a = mem_addr;
            @(posedge clock);
            #1;
            mem_rdata = fixed_en ? fixed_data : mem_fn(p1);
            if (g) p1 = a;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] model_addr();
        return 19'((m_bank ? BOFF : 0) + m_idx);
    endfunction

    task automatic pulse_frame(input bit b);
        frame_flag = 1'b1;
        display_bank = b;
        @(posedge clock);
        #1;
        frame_flag = 1'b0;
        m_idx = 0;
        m_bank = b;
    endtask

    // Called at #1 after a rising edge with the DUT idle.
    task automatic serve(input int gd, input bit drop, input bit fx, input logic [35:0] fd, input int lat);
        logic [18:0] ea, a0;
        logic [17:0] wi0;
        logic [35:0] ep;
        int          cyc;
        bit          stable;
        ea = model_addr();
        fixed_en = fx;
        fixed_data = fd;
        ep = fx ? fd : mem_fn(ea);
        vga_flag = 1'b1;
        mem_grant = 1'b0;
        @(posedge clock);
        #1;
        cyc = 1;
        chk("mem_req_rise", {63'd0, mem_req}, 64'd1);
        chk("mem_addr", {45'd0, mem_addr}, {45'd0, ea});
        a0 = mem_addr;
        wi0 = word_index;
        stable = 1'b1;
        repeat (gd) begin
            @(posedge clock);
            #1;
            cyc++;
            if (mem_req !== 1'b1 || mem_addr !== a0 || word_index !== wi0) stable = 1'b0;
        end
        if (gd > 0) chk("req_hold_stable", {63'd0, stable}, 64'd1);
        mem_grant = 1'b1;
        @(posedge clock);
        #1;
        cyc++;
        mem_grant = 1'b0;
        m_idx = (m_idx + 1) % FRAME;
        chk("mem_req_fall", {63'd0, mem_req}, 64'd0);
        chk("word_index", {46'd0, word_index}, 64'(m_idx));
        if (drop) vga_flag = 1'b0;
        while (done_vga !== 1'b1 && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("done_latency", 64'(cyc), 64'(lat));
        chk("vga_pixel", {28'd0, vga_pixel}, {28'd0, ep});
        if (!drop) begin
            @(posedge clock);
            #1;
            chk("done_hold", {63'd0, done_vga}, 64'd1);
            chk("pixel_hold", {28'd0, vga_pixel}, {28'd0, ep});
            vga_flag = 1'b0;
        end
        @(posedge clock);
        #1;
        chk("done_clear", {63'd0, done_vga}, 64'd0);
    endtask

    typedef struct {
        int          gd;
        bit          drop;
        bit          fx;
        logic [35:0] data;
        int          lat;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int   gd;
        tbl[0] = '{0, 1'b0, 1'b1, 36'h123456789, 4};
        tbl[1] = '{5, 1'b0, 1'b0, 36'h0, 9};
        tbl[2] = '{2, 1'b1, 1'b0, 36'h0, 6};
        tbl[3] = '{0, 1'b0, 1'b0, 36'h0, 4};
        tbl[4] = '{1, 1'b1, 1'b1, 36'hFFFFFFFFF, 5};
        n_chk = 0;
        n_fail = 0;
        m_idx = 0;
        m_bank = 1'b0;
        fixed_en = 1'b0;
        fixed_data = '0;
        frame_flag = 1'b0;
        display_bank = 1'b0;
        vga_flag = 1'b0;
        mem_grant = 1'b0;
        reset = 1'b1;
        #2;
        chk("rst_done", {63'd0, done_vga}, 64'd0);
        chk("rst_pixel", {28'd0, vga_pixel}, 64'd0);
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_addr", {45'd0, mem_addr}, 64'd0);
        chk("rst_widx", {46'd0, word_index}, 64'd0);
        chk("rst_overrun", {63'd0, overrun}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 5; i++) serve(tbl[i].gd, tbl[i].drop, tbl[i].fx, tbl[i].data, tbl[i].lat);
        for (int i = 0; i < 40; i++) begin
            gd = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) pulse_frame(1'($urandom_range(0, 1)));
            serve(gd, 1'($urandom_range(0, 1)), 1'b0, 36'h0, gd + 4);
        end
        pulse_frame(1'b1);
        for (int i = 0; i < FRAME; i++) serve(0, 1'b1, 1'b0, 36'h0, 4);
        chk("wrap_widx", {46'd0, word_index}, 64'd0);
        serve(0, 1'b0, 1'b0, 36'h0, 4);
        pulse_frame(1'b1);
        for (int i = 0; i < 500; i++) serve(0, 1'b1, 1'b0, 36'h0, 4);
        chk("widx_500", {46'd0, word_index}, 64'd500);
        chk("overrun_clear", {63'd0, overrun}, 64'd0);
        vga_flag = 1'b1;
        @(posedge clock);
        #1;
        chk("coinc_addr", {45'd0, mem_addr}, 64'(BOFF + 500));
        mem_grant = 1'b1;
        frame_flag = 1'b1;
        display_bank = 1'b0;
        @(posedge clock);
        #1;
        mem_grant = 1'b0;
        frame_flag = 1'b0;
        m_idx = 0;
        m_bank = 1'b0;
        chk("coinc_widx", {46'd0, word_index}, 64'd0);
        chk("coinc_overrun", {63'd0, overrun}, 64'd1);
        for (int i = 0; i < 40 && done_vga !== 1'b1; i++) begin
            @(posedge clock);
            #1;
        end
        chk("coinc_pixel", {28'd0, vga_pixel}, {28'd0, mem_fn(19'(BOFF + 500))});
        vga_flag = 1'b0;
        @(posedge clock);
        #1;
        serve(0, 1'b0, 1'b0, 36'h0, 4);
        chk("overrun_sticky", {63'd0, overrun}, 64'd1);
        vga_flag = 1'b1;
        @(posedge clock);
        #1;
        mem_grant = 1'b1;
        @(posedge clock);
        #1;
        mem_grant = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("wrst_done", {63'd0, done_vga}, 64'd0);
        chk("wrst_pixel", {28'd0, vga_pixel}, 64'd0);
        chk("wrst_req", {63'd0, mem_req}, 64'd0);
        chk("wrst_addr", {45'd0, mem_addr}, 64'd0);
        chk("wrst_widx", {46'd0, word_index}, 64'd0);
        chk("wrst_overrun", {63'd0, overrun}, 64'd0);
        vga_flag = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_idx = 0;
        m_bank = 1'b0;
        @(posedge clock);
        #1;
        serve(0, 1'b0, 1'b0, 36'h0, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_fetch.md
Name: vga_fetch

Overview:
- Memory-side producer for the VGA output stage.
- Answers each `vga_flag` request by reading one 36-bit word (two packed 18-bit YCrCb pixels) from the ZBT frame buffer through the memory arbiter.
- Presents the word on `vga_pixel` and completes a 4-phase handshake on `done_vga`.
- Keeps the raster read pointer, selects the display bank on each frame, and wraps at frame end.

Parameters:
- ADDR_W, 19, ZBT word-address width.
- DATA_W, 36, memory word width (two pixels).
- FRAME_WORDS, 153600, words per frame (640*480/2).
- BANK_OFFSET, 262144, base address of bank 1 (bank 0 base is 0).
- READ_LAT, 2, cycles from granted read to valid `mem_rdata`.

Ports:
- clock, input, 1, system clock (same domain as `vga_flag` generation).
- reset, input, 1, asynchronous active-high reset.
- frame_flag, input, 1, one-cycle pulse at start of frame.
- display_bank, input, 1, bank to display; sampled only on `frame_flag`.
- vga_flag, input, 1, pixel-pair request from the VGA stage.
- done_vga, output, 1, request served; `vga_pixel` valid.
- vga_pixel, output, DATA_W, pixel pair; [35:18] is the odd pixel, [17:0] the even pixel.
- mem_req, output, 1, read request to the arbiter.
- mem_addr, output, ADDR_W, read address; stable while `mem_req` is high.
- mem_grant, input, 1, arbiter accepts the request this cycle.
- mem_rdata, input, DATA_W, read data, valid READ_LAT cycles after grant.
- word_index, output, 18, debug: next word to fetch.
- overrun, output, 1, debug sticky: `frame_flag` arrived while a read was in flight.

Behaviour:
- Reset (async, active-high) values:
  - `done_vga`=0, `vga_pixel`=0, `mem_req`=0, `mem_addr`=0.
  - `word_index`=0, bank register=0, `overrun`=0, state=IDLE, latency counter=0.
- Address: `mem_addr` = (bank ? BANK_OFFSET : 0) + `word_index`; registered when the FSM enters REQ.
- FSM:
  - IDLE: if `vga_flag` && !`done_vga`, go to REQ and set `mem_req`=1.
  - REQ: hold `mem_req` and `mem_addr` until `mem_grant`. On grant: `mem_req`=0; latency counter=READ_LAT-1; `word_index` advances (wraps to 0 after FRAME_WORDS-1); go to WAIT.
  - WAIT: count down. At 0, capture `mem_rdata` into `vga_pixel`, set `done_vga`=1, go to DONE.
  - DONE: hold `done_vga`=1 and `vga_pixel`. When `vga_flag`=0, clear `done_vga` next cycle and go to IDLE.
- Latency: with grant in the request cycle, `done_vga` rises READ_LAT+2 clocks after `vga_flag` rises.
- `vga_flag` dropping during REQ or WAIT:
  - The read still completes and `vga_pixel` updates.
  - `done_vga` pulses for exactly 1 cycle, then the FSM returns to IDLE.
  - No request is ever abandoned once issued.
- `frame_flag`:
  - Sets `word_index` to 0 and latches `display_bank` into the bank register.
  - If it arrives in REQ, the pending address is not changed. The grant-time increment is overridden: `word_index`=0 wins. `overrun` is set.
  - If it arrives in WAIT, `overrun` is also set.
  - If it coincides with a grant, the reset to 0 wins over the increment.
- `vga_pixel` only changes on data capture, never while `done_vga`=1.
- `overrun` clears only on reset.

Decomposition:
- Shared params include: `LOG_MEM`, `LOG_ADDR`, `FRAME_WORDS`, `BANK_OFFSET`, `ZBT_READ_LAT`, and FSM state encodings (IDLE, REQ, WAIT, DONE).
- One sub-module, `fetch_addr_gen`:
  - Holds the bank register and the `word_index` counter.
  - Handles wrap and `frame_flag` priority.
  - Outputs the address.
- The FSM and data capture stay in the top module.

Test Plan:
- Reset mid-WAIT (`reset` pulsed asynchronously, between clock edges) -> all outputs 0 immediately; FSM in IDLE; first request afterwards reads address 0.
- Single request, `mem_grant` tied 1, READ_LAT=2, `mem_rdata`=36'h123456789 -> `mem_addr`=0; `done_vga` high at cycle 4 after `vga_flag` rises; `vga_pixel`=36'h123456789; `done_vga` low 1 cycle after `vga_flag` falls.
- Grant withheld 5 cycles -> `mem_req` and `mem_addr` stable for all 5 cycles; `word_index` unchanged until grant.
- Wrap: serve 153600 requests with `display_bank`=1 latched -> addresses 262144..415743, then 262144 again; `word_index` returns to 0.
- `frame_flag` coincident with grant at `word_index`=500 -> that read uses address 500; `word_index`=0 afterwards; `overrun`=1; new bank used on the next request.
- `vga_flag` dropped during WAIT -> `vga_pixel` updates; `done_vga` 1-cycle pulse; next request served normally from IDLE.
